utopia1_atm_tx: RTL and testbench
=================================

Name: utopia1_atm_tx

Overview:
ATM-layer UTOPIA Level-1 cell transmitter, the transmit-direction neighbour of the receive stage. It accepts one complete 53-byte UNI cell from the core over a valid/ready handshake and serialises it byte-by-byte onto the UTOPIA Tx bus. Byte transfer is gated per byte by the PHY's cell-available (clav) signal. It optionally regenerates the HEC byte and counts transmitted cells.

Parameters:
GEN_HEC, 1, 1 = replace header byte 4 with computed HEC; 0 = send byte 4 from cell_in unchanged
CNT_W, 16, width of transmitted-cell counter

Ports:
clk_in  input  1  25 MHz UTOPIA Tx clock
reset_n  input  1  asynchronous active-low reset
clk_out  output  1  Tx clock out to PHY, = clk_in (combinational passthrough)
cell_in  input  424  UNI cell; byte k at [423-8k -: 8]; byte0 = {GFC,VPI[7:4]}, byte4 = HEC, bytes 5..52 = payload
cell_valid  input  1  core offers cell_in
cell_ready  output  1  block can accept a cell
clav  input  1  PHY can take a byte this cycle
data  output  8  UTOPIA Tx data
soc  output  1  start-of-cell, high with byte 0 only
en_n  output  1  active-low Tx enable, low while data is valid
cell_sent  output  1  one-cycle pulse after byte 52 is driven
cell_count  output  CNT_W  number of cells sent, wraps

Behaviour:
- All outputs registered except clk_out. Reset values: data=0, soc=0, en_n=1, cell_ready=0, cell_sent=0, cell_count=0, state=RESET, byte index=0.
- Reset assertion mid-cell: outputs take reset values immediately; the latched cell is discarded and never resumed.
- States: RESET, IDLE, SEND.
- RESET: at the first posedge, go to IDLE and set cell_ready=1.
- IDLE: cell_ready=1. On a posedge with cell_valid && cell_ready:
  - latch the 53 bytes;
  - if GEN_HEC=1, latch HEC = CRC-8(bytes 0..3, poly x^8+x^2+x+1, init 0x00, MSB first) XOR 0x55;
  - set idx=0, cell_ready<=0, go to SEND.
- cell_valid without cell_ready is ignored; cell_in is not sampled outside acceptance.
- SEND, each posedge:
  - clav=1: data<=byte[idx] (byte 4 = HEC if GEN_HEC), soc<=(idx==0), en_n<=0, idx++.
  - clav=0: en_n<=1, soc<=0, data holds, idx holds (pause, no byte lost or duplicated).
- Byte 52 registered: go to IDLE, cell_ready<=1, cell_sent<=1 next cycle, cell_count++ (wraps modulo 2^CNT_W).
- Next posedge in IDLE: en_n<=1, soc<=0, cell_sent<=0.
- Latency: accept at edge N; if clav=1 at N+1, soc/byte0 are valid after N+1.
- Back-to-back: minimum one cycle with en_n=1 between the last byte of a cell and soc of the next.
- idx is 6 bits (0..52); values above 52 are unreachable. Any illegal state goes to RESET.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release -> en_n=1, soc=0, data=0, cell_ready=0; cell_ready=1 after first edge.
- Single cell, clav=1, GEN_HEC=1, header 00 00 00 00, payload bytes = 0x01..0x30 -> 53 consecutive en_n=0 cycles; soc only on byte0; byte4=0x55; bytes 5..52 = 0x01..0x30; cell_sent pulses once; cell_count=1.
- HEC computation: header 00 00 00 01, input byte4=0xFF -> sent byte4=0x52; same cell with GEN_HEC=0 -> byte4=0xFF.
- clav pauses: drop clav for 2 cycles at idx 0 (before soc) and at idx 20 -> en_n=1 during the pauses; byte sequence intact with no repeat/skip; soc exactly once.
- Back-to-back cells with cell_valid held high -> second soc exactly 2 cycles after byte 52 of the first cell; cell_count=2; cell_ready low throughout each SEND.
- Reset mid-cell: assert reset_n=0 at idx 30 -> en_n=1 immediately; after release, next accepted cell starts at soc/byte0; cell_count=0 for the aborted cell. Separately, send 65536 cells with CNT_W=16 -> cell_count wraps to 0.

Source files
------------

// File: rtl/utopia1_atm_tx.sv
// UTOPIA Level-1 ATM-layer transmitter: takes one 53-byte cell over valid/ready
// and serialises it onto the Tx bus, pausing per byte on clav, with optional HEC regeneration.
module utopia1_atm_tx #(
  parameter int GEN_HEC = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             reset_n,
  output logic             clk_out,
  input  logic [423:0]     cell_in,
  input  logic             cell_valid,
  output logic             cell_ready,
  input  logic             clav,
  output logic [7:0]       data,
  output logic             soc,
  output logic             en_n,
  output logic             cell_sent,
  output logic [CNT_W-1:0] cell_count
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd52;

  state_t           state_reg, state_next;
  logic [423:0]     cell_reg, cell_next;
  logic [5:0]       idx_reg, idx_next;
  logic [7:0]       data_reg, data_next;
  logic             soc_reg, soc_next;
  logic             en_n_reg, en_n_next;
  logic             ready_reg, ready_next;
  logic             sent_reg, sent_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [7:0]       hec;
  logic [423:0]     cell_accept;

  // CRC-8 (x^8+x^2+x+1), init 0, MSB first, over the four header bytes
  function automatic logic [7:0] crc8_hdr(input logic [31:0] hdr);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ hdr[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  assign hec = crc8_hdr(cell_in[423:392]) ^ 8'h55;

  // HEC is folded into the latched copy so the send path is a plain byte shifter
  assign cell_accept = (GEN_HEC != 0) ? {cell_in[423:392], hec, cell_in[383:0]} : cell_in;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_RESET;
      cell_reg  <= '0;
      idx_reg   <= '0;
      data_reg  <= '0;
      soc_reg   <= 1'b0;
      en_n_reg  <= 1'b1;
      ready_reg <= 1'b0;
      sent_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      cell_reg  <= cell_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      soc_reg   <= soc_next;
      en_n_reg  <= en_n_next;
      ready_reg <= ready_next;
      sent_reg  <= sent_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cell_next  = cell_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    soc_next   = soc_reg;
    en_n_next  = en_n_reg;
    ready_next = ready_reg;
    sent_next  = sent_reg;
    count_next = count_reg;

    case (state_reg)
      ST_RESET: begin
        state_next = ST_IDLE;
        ready_next = 1'b1;
        en_n_next  = 1'b1;
        soc_next   = 1'b0;
        sent_next  = 1'b0;
        idx_next   = '0;
      end

      ST_IDLE: begin
        en_n_next  = 1'b1;
        soc_next   = 1'b0;
        sent_next  = 1'b0;
        ready_next = 1'b1;
        if (cell_valid && ready_reg) begin
          cell_next  = cell_accept;
          idx_next   = '0;
          ready_next = 1'b0;
          state_next = ST_SEND;
        end
      end

      ST_SEND: begin
        ready_next = 1'b0;
        sent_next  = 1'b0;
        if (clav) begin
          data_next = cell_reg[423:416];
          cell_next = {cell_reg[415:0], 8'h00};
          soc_next  = (idx_reg == 6'd0);
          en_n_next = 1'b0;
          if (idx_reg == LAST_IDX) begin
            idx_next   = '0;
            state_next = ST_IDLE;
            ready_next = 1'b1;
            sent_next  = 1'b1;
            count_next = count_reg + CNT_W'(1);
          end else begin
            idx_next = idx_reg + 6'd1;
          end
        end else begin
          // PHY stall: bus idles, cursor holds so nothing is lost or repeated
          en_n_next = 1'b1;
          soc_next  = 1'b0;
        end
      end

      default: begin
        state_next = ST_RESET;
        ready_next = 1'b0;
        en_n_next  = 1'b1;
        soc_next   = 1'b0;
        sent_next  = 1'b0;
        idx_next   = '0;
      end
    endcase
  end

  assign clk_out    = clk_in;
  assign cell_ready = ready_reg;
  assign data       = data_reg;
  assign soc        = soc_reg;
  assign en_n       = en_n_reg;
  assign cell_sent  = sent_reg;
  assign cell_count = count_reg;

endmodule

// File: tb/tb_utopia1_atm_tx.sv
// Directed bench for utopia1_atm_tx: an HEC-generating instance and a raw-byte4
// instance with a 3-bit counter run in lockstep on shared stimulus.
module tb_utopia1_atm_tx;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic [423:0] cell_in;
  logic         cell_valid;
  logic         clav;

  logic         clk_out_a, ready_a, soc_a, en_n_a, sent_a;
  logic [7:0]   data_a;
  logic [15:0]  count_a;
  logic         clk_out_b, ready_b, soc_b, en_n_b, sent_b;
  logic [7:0]   data_b;
  logic [2:0]   count_b;

  int checks   = 0;
  int failures = 0;
  int n_cells  = 0;

  always #5 clk_in = ~clk_in;

  utopia1_atm_tx #(.GEN_HEC(1), .CNT_W(16)) dut_hec (
    .clk_in(clk_in), .reset_n(reset_n), .clk_out(clk_out_a),
    .cell_in(cell_in), .cell_valid(cell_valid), .cell_ready(ready_a),
    .clav(clav), .data(data_a), .soc(soc_a), .en_n(en_n_a),
    .cell_sent(sent_a), .cell_count(count_a)
  );

  utopia1_atm_tx #(.GEN_HEC(0), .CNT_W(3)) dut_raw (
    .clk_in(clk_in), .reset_n(reset_n), .clk_out(clk_out_b),
    .cell_in(cell_in), .cell_valid(cell_valid), .cell_ready(ready_b),
    .clav(clav), .data(data_b), .soc(soc_b), .en_n(en_n_b),
    .cell_sent(sent_b), .cell_count(count_b)
  );

  typedef struct {
    logic [31:0] hdr;
    logic [7:0]  b4;
    logic [7:0]  hec;   // hand-computed CRC-8 ^ 0x55
    logic [7:0]  seed;  // payload byte k = seed + (k-5)
    int          p1;    // byte index where clav drops for 2 cycles, -1 = none
    int          p2;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] rxa[0:127];
  logic [7:0] rxb[0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [423:0] make_cell(input logic [31:0] hdr, input logic [7:0] b4,
                                             input logic [7:0] seed);
    logic [423:0] c;
    c = '0;
    c[423:392] = hdr;
    c[391:384] = b4;
    for (int k = 5; k < 53; k++) c[423-8*k -: 8] = seed + 8'(k - 5);
    return c;
  endfunction

  function automatic logic [7:0] cell_byte(input logic [423:0] c, input int k);
    logic [423:0] t;
    t = c << (8 * k);
    return t[423:416];
  endfunction

  task automatic wait_accept(output bit acc);
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(posedge clk_in); #1;
      if (!ready_a) acc = 1;
    end
  endtask

  task automatic run_cell(input int v);
    logic [423:0] c;
    bit acc, done, p1_done, p2_done;
    int nb_a, nb_b, idle_cyc, soc_cnt, soc_bad, ready_bad, pause_cnt, exp_pause;
    int bad_a, bad_b, cyc;
    logic [7:0] ea;
    c = make_cell(vecs[v].hdr, vecs[v].b4, vecs[v].seed);
    cell_in = c; cell_valid = 1'b1; clav = 1'b1;
    wait_accept(acc);
    check($sformatf("v%0d accept", v), 32'(acc), 32'd1);
    cell_valid = 1'b0;
    done = 0; p1_done = 0; p2_done = 0;
    nb_a = 0; nb_b = 0; idle_cyc = 0; soc_cnt = 0; soc_bad = 0; ready_bad = 0;
    pause_cnt = 0; exp_pause = 0; cyc = 0;
    while (!done && cyc < 200) begin
      if (pause_cnt > 0) begin clav = 1'b0; pause_cnt--; end
      else if (!p1_done && vecs[v].p1 == nb_a) begin
        p1_done = 1; clav = 1'b0; pause_cnt = 1; exp_pause += 2;
      end else if (!p2_done && vecs[v].p2 == nb_a) begin
        p2_done = 1; clav = 1'b0; pause_cnt = 1; exp_pause += 2;
      end else clav = 1'b1;
      @(posedge clk_in); #1;
      cyc++;
      if (soc_a) begin
        soc_cnt++;
        if (en_n_a || nb_a != 0) soc_bad++;
      end
      if (!en_n_a) begin if (nb_a < 128) rxa[nb_a] = data_a; nb_a++; end
      else idle_cyc++;
      if (!en_n_b) begin if (nb_b < 128) rxb[nb_b] = data_b; nb_b++; end
      if (sent_a) done = 1;
      else if (ready_a) ready_bad++;
    end
    clav = 1'b1;
    n_cells++;
    check($sformatf("v%0d cell_sent seen", v), 32'(done), 32'd1);
    check($sformatf("v%0d bytes hec", v), nb_a, 32'd53);
    check($sformatf("v%0d bytes raw", v), nb_b, 32'd53);
    bad_a = 0; bad_b = 0;
    for (int k = 0; k < 53; k++) begin
      ea = (k == 4) ? vecs[v].hec : cell_byte(c, k);
      if (rxa[k] !== ea) bad_a++;
      if (rxb[k] !== cell_byte(c, k)) bad_b++;
    end
    check($sformatf("v%0d stream errs hec", v), bad_a, 32'd0);
    check($sformatf("v%0d stream errs raw", v), bad_b, 32'd0);
    check($sformatf("v%0d byte4 hec", v), 32'(rxa[4]), 32'(vecs[v].hec));
    check($sformatf("v%0d byte4 raw", v), 32'(rxb[4]), 32'(vecs[v].b4));
    check($sformatf("v%0d soc count", v), soc_cnt, 32'd1);
    check($sformatf("v%0d soc misplaced", v), soc_bad, 32'd0);
    check($sformatf("v%0d pause idle cycles", v), idle_cyc, exp_pause);
    check($sformatf("v%0d ready during send", v), ready_bad, 32'd0);
    check($sformatf("v%0d count hec", v), 32'(count_a), n_cells);
    check($sformatf("v%0d count raw", v), 32'(count_b), n_cells % 8);
    @(posedge clk_in); #1;
    check($sformatf("v%0d sent drop", v), 32'(sent_a), 32'd0);
    check($sformatf("v%0d en_n idle", v), 32'(en_n_a), 32'd1);
    check($sformatf("v%0d ready idle", v), 32'(ready_a), 32'd1);
    $display("cell v%0d hdr=%08h byte4 hec=%02h raw=%02h bytes=%0d idle=%0d count=%0d",
             v, vecs[v].hdr, rxa[4], rxb[4], nb_a, idle_cyc, count_a);
  endtask

  initial begin
    logic [423:0] c;
    int soc_pos[2];
    int sent_pos[2];
    int n_soc, n_sent, nb, gap, ready_bad, bad;
    bit acc;

    vecs[0] = '{32'h0000_0000, 8'h00, 8'h55, 8'h01, -1, -1};
    vecs[1] = '{32'h0000_0001, 8'hFF, 8'h52, 8'h40, -1, -1};
    vecs[2] = '{32'h0000_0080, 8'h11, 8'hDC, 8'h80,  0, 20};
    vecs[3] = '{32'h0000_00FF, 8'h22, 8'hA6, 8'hC0,  4, 52};
    vecs[4] = '{32'h0000_0100, 8'h33, 8'h40, 8'h10, -1, -1};
    vecs[5] = '{32'h0000_0002, 8'h44, 8'h5B, 8'h20,  1, -1};

    reset_n = 1'b0; cell_in = '0; cell_valid = 1'b0; clav = 1'b1;

    // reset held for 3 edges
    repeat (3) @(posedge clk_in);
    #1;
    check("rst en_n", 32'(en_n_a), 32'd1);
    check("rst soc", 32'(soc_a), 32'd0);
    check("rst data", 32'(data_a), 32'd0);
    check("rst ready", 32'(ready_a), 32'd0);
    check("rst sent", 32'(sent_a), 32'd0);
    check("rst count", 32'(count_a), 32'd0);
    check("clk_out", 32'(clk_out_a), 32'(clk_in));
    reset_n = 1'b1;
    #1;
    check("ready before edge", 32'(ready_a), 32'd0);
    @(posedge clk_in); #1;
    check("ready after edge", 32'(ready_a), 32'd1);
    check("en_n after edge", 32'(en_n_a), 32'd1);
    $display("reset done ready=%0d en_n=%0d", ready_a, en_n_a);

    for (int v = 0; v < 6; v++) run_cell(v);

    // back-to-back: cell_valid held high across two cells
    c = make_cell(vecs[0].hdr, vecs[0].b4, vecs[0].seed);
    cell_in = c; cell_valid = 1'b1; clav = 1'b1;
    n_soc = 0; n_sent = 0; nb = 0; gap = 0; ready_bad = 0;
    soc_pos = '{0, 0}; sent_pos = '{0, 0};
    for (int cyc = 0; cyc < 150 && n_sent < 2; cyc++) begin
      @(posedge clk_in); #1;
      if (soc_a) begin if (n_soc < 2) soc_pos[n_soc] = cyc; n_soc++; end
      if (!en_n_a) begin if (nb < 128) rxa[nb] = data_a; nb++; end
      else if (n_soc == 1) gap++;
      if (sent_a) begin if (n_sent < 2) sent_pos[n_sent] = cyc; n_sent++; end
      else if (!en_n_a && ready_a) ready_bad++;
    end
    cell_valid = 1'b0;
    n_cells += 2;
    bad = 0;
    for (int k = 0; k < 106; k++)
      if (rxa[k] !== ((k % 53 == 4) ? vecs[0].hec : cell_byte(c, k % 53))) bad++;
    check("b2b sent pulses", n_sent, 32'd2);
    check("b2b soc count", n_soc, 32'd2);
    check("b2b soc gap", soc_pos[1] - sent_pos[0], 32'd2);
    check("b2b idle between", gap, 32'd1);
    check("b2b bytes", nb, 32'd106);
    check("b2b stream errs", bad, 32'd0);
    check("b2b ready during send", ready_bad, 32'd0);
    check("b2b count hec", 32'(count_a), n_cells);
    check("b2b count raw wrap", 32'(count_b), 32'd0);
    $display("b2b socs=%0d gap=%0d bytes=%0d count=%0d raw_count=%0d",
             n_soc, soc_pos[1] - sent_pos[0], nb, count_a, count_b);
    @(posedge clk_in); #1;

    // reset asserted mid-cell at idx 30
    cell_in = make_cell(vecs[1].hdr, vecs[1].b4, vecs[1].seed);
    cell_valid = 1'b1; clav = 1'b1;
    wait_accept(acc);
    check("mid accept", 32'(acc), 32'd1);
    cell_valid = 1'b0;
    nb = 0;
    for (int cyc = 0; cyc < 100 && nb < 30; cyc++) begin
      @(posedge clk_in); #1;
      if (!en_n_a) nb++;
    end
    check("mid bytes before reset", nb, 32'd30);
    reset_n = 1'b0;
    #1;
    check("mid rst en_n", 32'(en_n_a), 32'd1);
    check("mid rst soc", 32'(soc_a), 32'd0);
    check("mid rst data", 32'(data_a), 32'd0);
    check("mid rst ready", 32'(ready_a), 32'd0);
    check("mid rst count", 32'(count_a), 32'd0);
    check("mid rst count raw", 32'(count_b), 32'd0);
    n_cells = 0;
    repeat (2) @(posedge clk_in);
    #1;
    reset_n = 1'b1;
    @(posedge clk_in); #1;
    check("mid ready after release", 32'(ready_a), 32'd1);
    $display("mid-cell reset at idx %0d en_n=%0d count=%0d", nb, en_n_a, count_a);
    run_cell(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
